// File: rtl/pipelined_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_adder_pkg
// Shared definitions for the pipelined add/subtract unit.
//   - DEFAULT_WIDTH / DEFAULT_STAGES : default geometry of the unit
//   - slice_width()                  : bits handled by each pipeline slice
//   - beat_t                         : layout of one in-flight beat for the
//                                      default geometry (the top builds the
//                                      same layout from its own parameters)
// -----------------------------------------------------------------------------
package pipelined_adder_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    // One beat in flight: completed low sum slices, carry into the next slice,
    // the operand bits still to be added, and the operation select.
    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] sum;
        logic                     carry;
        logic [DEFAULT_WIDTH-1:0] a_rem;
        logic [DEFAULT_WIDTH-1:0] b_rem;
        logic                     sub;
    } beat_t;

endpackage

// File: rtl/pipelined_adder_slice.sv
// -----------------------------------------------------------------------------
// adder_slice
// Combinational SW-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a, b   in  SW  operand slices (b already inverted for subtraction)
//   cin    in  1   carry into the LSB cell
//   sum    out SW  slice sum
//   cout   out 1   carry out of the MSB cell
//   c_msb  out 1   carry into the MSB cell (signed-overflow detection)
// -----------------------------------------------------------------------------
module adder_slice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          c_msb
);

    // The carry is a loop-local variable so the ripple stays a simple
    // chain of full-adder cells without a self-referencing vector.
    always_comb begin
        logic c;
        c     = cin;
        sum   = '0;
        c_msb = cin;
        for (int i = 0; i < SW; i++) begin
            if (i == SW - 1) begin
                c_msb = c;
            end
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
// Pipelined WIDTH-bit add/subtract unit. The operation is cut into STAGES
// slices of WIDTH/STAGES bits; slice k is added in register stage k using the
// carry registered by stage k-1, so the carry ripples one stage per cycle.
// Each stage is elastic (own valid bit) with valid/ready on both sides.
// Optional feature macro: PIPELINED_ADDER_OVF_EN adds the out_ovf port.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake
//   in_a, in_b          operands
//   in_sub              1: A-B (A + ~B + 1), 0: A+B+in_cin
//   in_cin              carry-in for add mode
//   out_valid/out_ready output handshake
//   out_sum, out_cout   result and carry-out (sub: 1 = no borrow)
//   out_ovf             signed overflow (PIPELINED_ADDER_OVF_EN only)
// -----------------------------------------------------------------------------
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int SW = slice_width(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
        $error("pipelined_adder: STAGES must be in 1..WIDTH");
    end
    if (STAGES >= 1 && (WIDTH % STAGES) != 0) begin : g_bad_split
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    // Full-width fields keep slice indexing uniform across stages; bits a
    // stage never touches are constant and fall away in synthesis.
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
`ifdef PIPELINED_ADDER_OVF_EN
        logic             ovf;
`endif
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        logic             sub;
    } stage_t;

    logic [STAGES:0]   load;
    logic [STAGES-1:0] valid_vec;
    stage_t            stage_arr [STAGES];
    logic              accept;

    // The output register is free when empty or being drained.
    assign load[STAGES] = out_ready;
    assign in_ready     = load[0] && !rst;
    assign accept       = in_valid && in_ready;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        stage_t          src;
        logic            src_valid;
        logic [SW-1:0]   a_sl;
        logic [SW-1:0]   b_sl;
        logic [SW-1:0]   s_sl;
        logic            cout_sl;
        logic            cmsb_sl;
        stage_t          st_d;
        stage_t          st_q;
        logic            v_d;
        logic            v_q;
        logic            unused_bits;

        if (gi == 0) begin : g_head
            always_comb begin
                src       = '0;
                src.carry = in_sub ? 1'b1 : in_cin;
                src.a_rem = in_a;
                src.b_rem = in_b;
                src.sub   = in_sub;
            end
            assign src_valid = accept;
        end else begin : g_body
            assign src       = stage_arr[gi-1];
            assign src_valid = valid_vec[gi-1];
        end

        assign a_sl = src.a_rem[gi*SW +: SW];
        assign b_sl = src.b_rem[gi*SW +: SW] ^ {SW{src.sub}};

        adder_slice #(.SW(SW)) u_slice (
            .a     (a_sl),
            .b     (b_sl),
            .cin   (src.carry),
            .sum   (s_sl),
            .cout  (cout_sl),
            .c_msb (cmsb_sl)
        );

        // A stage may take a new beat if it is empty (bubble collapse) or its
        // current beat moves on this cycle.
        assign load[gi] = !v_q || load[gi+1];

        always_comb begin
            st_d = st_q;
            v_d  = v_q;
            if (load[gi]) begin
                v_d = src_valid;
                if (src_valid) begin
                    st_d                   = src;
                    st_d.sum[gi*SW +: SW]  = s_sl;
                    st_d.carry             = cout_sl;
`ifdef PIPELINED_ADDER_OVF_EN
                    // Only the last stage's value reaches out_ovf.
                    st_d.ovf               = cmsb_sl ^ cout_sl;
`endif
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                st_q <= '0;
                v_q  <= 1'b0;
            end else begin
                st_q <= st_d;
                v_q  <= v_d;
            end
        end

        assign stage_arr[gi] = st_q;
        assign valid_vec[gi] = v_q;

        // Operand bits already consumed and slice-MSB carries of inner
        // stages are intentionally dropped.
        assign unused_bits = ^{st_q, src, cmsb_sl};
    end

    logic unused_tail;
    assign unused_tail = ^stage_arr[STAGES-1];

    assign out_valid = valid_vec[STAGES-1];
    assign out_sum   = stage_arr[STAGES-1].sum;
    assign out_cout  = stage_arr[STAGES-1].carry;
`ifdef PIPELINED_ADDER_OVF_EN
    assign out_ovf   = stage_arr[STAGES-1].ovf;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

    localparam int W  = 32;
    localparam int S  = 4;
    localparam int W3 = 3;
    localparam int S3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          in_valid, in_ready, in_sub, in_cin;
    logic [W-1:0]  in_a, in_b, out_sum;
    logic          out_valid, out_ready, out_cout;
`ifdef PIPELINED_ADDER_OVF_EN
    logic          out_ovf;
`endif

    logic          in_valid3, in_ready3, in_sub3, in_cin3;
    logic [W3-1:0] in_a3, in_b3, out_sum3;
    logic          out_valid3, out_ready3, out_cout3;
`ifdef PIPELINED_ADDER_OVF_EN
    logic          out_ovf3;
`endif

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout)
`ifdef PIPELINED_ADDER_OVF_EN
        , .out_ovf(out_ovf)
`endif
    );

    pipelined_adder #(.WIDTH(W3), .STAGES(S3)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .in_a(in_a3), .in_b(in_b3), .in_sub(in_sub3), .in_cin(in_cin3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_sum(out_sum3), .out_cout(out_cout3)
`ifdef PIPELINED_ADDER_OVF_EN
        , .out_ovf(out_ovf3)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    logic bp_en = 1'b0;
    logic lat_check = 1'b1;
    int count3 = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Reference model: plain wide arithmetic on the operands.
    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           t_in;
    } exp_t;

    exp_t q[$];

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cin, input int t);
        exp_t e;
        logic [W:0] wide;
        longint sr;
        if (sub) begin
            e.sum  = a - b;
            e.cout = (a >= b);
            sr     = longint'($signed(a)) - longint'($signed(b));
        end else begin
            wide   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            e.sum  = wide[W-1:0];
            e.cout = wide[W];
            sr     = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        end
        e.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.t_in = t;
        return e;
    endfunction

    typedef struct {
        int val;
        int t_in;
    } exp3_t;

    exp3_t q3[$];

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    // out_ready driver: always ready, or 1-of-3 random when backpressure is on.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? ($urandom_range(0, 2) == 0) : 1'b1;
        end
    end

    // 32-bit monitor / scoreboard
    initial begin : mon32
        exp_t e;
        logic hold;
        logic [W-1:0] hs;
        logic hc;
        hold = 1'b0;
        hs   = '0;
        hc   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("stall_valid", 64'(out_valid), 64'd1);
                    check("stall_sum", 64'(out_sum), 64'(hs));
                    check("stall_cout", 64'(out_cout), 64'(hc));
                end
                if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_sub, in_cin, cycle));
                if (out_valid) begin
                    if (q.size() == 0) begin
                        check("spurious_out_valid", 64'(out_valid), 64'd0);
                    end else if (out_ready) begin
                        e = q.pop_front();
                        $display("beat t_in=%0d sum=%08h cout=%0d exp_sum=%08h exp_cout=%0d",
                                 e.t_in, out_sum, out_cout, e.sum, e.cout);
                        check("sum", 64'(out_sum), 64'(e.sum));
                        check("cout", 64'(out_cout), 64'(e.cout));
`ifdef PIPELINED_ADDER_OVF_EN
                        check("ovf", 64'(out_ovf), 64'(e.ovf));
`endif
                        if (lat_check) check("latency", 64'(cycle - e.t_in), 64'(S));
                    end
                end
                hold = out_valid && !out_ready;
                hs   = out_sum;
                hc   = out_cout;
            end
        end
    end

    // 3-bit monitor
    initial begin : mon3
        exp3_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                q3.delete();
            end else begin
                if (in_valid3 && in_ready3) begin
                    e.val  = int'(in_a3) + int'(in_b3) + int'(in_cin3);
                    e.t_in = cycle;
                    q3.push_back(e);
                end
                if (out_valid3) begin
                    if (q3.size() == 0) begin
                        check("add3_spurious", 64'(out_valid3), 64'd0);
                    end else begin
                        e = q3.pop_front();
                        count3++;
                        check("add3_result", 64'({out_cout3, out_sum3}), 64'(e.val));
                        check("add3_latency", 64'(cycle - e.t_in), 64'(S3));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin);
        int waited;
        logic acc;
        waited   = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_cin   = cin;
        while (!acc && waited < 200) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            waited++;
        end
        if (!acc) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_rand();
        send($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin : main
        int t0;
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
        in_valid3 = 1'b0; in_a3 = '0; in_b3 = '0; in_sub3 = 1'b0; in_cin3 = 1'b0;
        out_ready3 = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_cout", 64'(out_cout), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid3", 64'(out_valid3), 64'd0);
`ifdef PIPELINED_ADDER_OVF_EN
        check("rst_out_ovf", 64'(out_ovf), 64'd0);
`endif
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 64'(in_ready), 64'd1);
        check("in_ready3_after_rst", 64'(in_ready3), 64'd1);
        tick();

        // Exhaustive 3-bit add
        for (int i = 0; i < 128; i++) begin
            in_valid3 = 1'b1;
            in_a3     = i[2:0];
            in_b3     = i[5:3];
            in_cin3   = i[6];
            in_sub3   = 1'b0;
            tick();
        end
        in_valid3 = 1'b0;
        repeat (S3 + 4) tick();
        check("add3_count", 64'(count3), 64'd128);

        // Directed corner cases
        lat_check = 1'b1;
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'd5, 32'd7, 1'b1, 1'b0);
        send(32'h8000_0000, 32'd1, 1'b1, 1'b0);
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        send(32'd0, 32'd0, 1'b1, 1'b1);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        drain();

        // Throughput: 20 back-to-back beats
        t0 = cycle;
        for (int i = 0; i < 20; i++) send_rand();
        check("tput_accept_cycles", 64'(cycle - t0), 64'd20);
        drain();

        // Backpressure
        lat_check = 1'b0;
        bp_en = 1'b1;
        for (int i = 0; i < 10; i++) send_rand();
        drain();
        bp_en = 1'b0;
        repeat (2) tick();

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) send_rand();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        tick();
        repeat (10) tick();

        // Normal operation after the mid-stream reset
        lat_check = 1'b1;
        for (int i = 0; i < 4; i++) send_rand();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
